// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: maps a 2-read/1-write register interface onto a dual-port BRAM.
// Zero-fills the RAM after reset, hardwires x0, forwards same-cycle writes and stalls rs1 when neither port is free.
module regfile_port_ctrl #(
  parameter int DATAW = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [REGW-1:0]  req_rs1,
  input  logic [REGW-1:0]  req_rs2,
  output logic             rsp_valid,
  output logic [DATAW-1:0] rsp_rs1_data,
  output logic [DATAW-1:0] rsp_rs2_data,
  input  logic             wr_en,
  input  logic [REGW-1:0]  wr_addr,
  input  logic [DATAW-1:0] wr_data,
  output logic             init_done,
  output logic             ram_wea,
  output logic             ram_web,
  output logic [REGW-1:0]  ram_addra,
  output logic [REGW-1:0]  ram_addrb,
  output logic [DATAW-1:0] ram_dina,
  output logic [DATAW-1:0] ram_dinb,
  input  logic [DATAW-1:0] ram_douta,
  input  logic [DATAW-1:0] ram_doutb
);
  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_FWD, SRC_B, SRC_A} src_t;
  state_t            state_q;
  logic [REGW-2:0]   cnt_q;
  logic              init_done_q, rsp_valid_q;
  src_t              sel1_q, sel2_q, sel1_d, sel2_d;
  logic [DATAW-1:0]  fwd_q, hold1_q, hold2_q, val1, val2;
  logic              run, we;
  always_comb begin
    run       = state_q == RUN;
    we        = run && wr_en && wr_addr != '0;
    req_ready = run && !(we && req_rs1 != '0 && req_rs1 != wr_addr && req_rs1 != req_rs2);
    sel1_d    = req_rs1 == '0 ? SRC_ZERO : (we && req_rs1 == wr_addr) ? SRC_FWD :
                req_rs1 == req_rs2 ? SRC_B : SRC_A;
    sel2_d    = req_rs2 == '0 ? SRC_ZERO : (we && req_rs2 == wr_addr) ? SRC_FWD : SRC_B;
    // Outputs are forced to zero while reset is asserted, even though INIT is already entered.
    ram_wea   = !rst && (run ? we : 1'b1);
    ram_web   = !rst && !run;
    ram_addra = rst ? '0 : run ? (we ? wr_addr : req_rs1) : {cnt_q, 1'b0};
    ram_addrb = rst ? '0 : run ? req_rs2 : {cnt_q, 1'b1};
    ram_dina  = (!rst && we) ? wr_data : '0;
    ram_dinb  = '0;
    val1      = sel1_q == SRC_ZERO ? '0 : sel1_q == SRC_FWD ? fwd_q :
                sel1_q == SRC_B ? ram_doutb : ram_douta;
    val2      = sel2_q == SRC_ZERO ? '0 : sel2_q == SRC_FWD ? fwd_q : ram_doutb;
    rsp_valid    = rsp_valid_q;
    rsp_rs1_data = rsp_valid_q ? val1 : hold1_q;
    rsp_rs2_data = rsp_valid_q ? val2 : hold2_q;
    init_done    = init_done_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      sel1_q      <= SRC_ZERO;
      sel2_q      <= SRC_ZERO;
      fwd_q       <= '0;
      hold1_q     <= '0;
      hold2_q     <= '0;
    end else begin
      if (!run) begin
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
      end
      rsp_valid_q <= req_valid && req_ready;
      if (req_valid && req_ready) begin
        sel1_q <= sel1_d;
        sel2_q <= sel2_d;
        fwd_q  <= wr_data;
      end
      if (rsp_valid_q) begin
        hold1_q <= val1;
        hold2_q <= val2;
      end
    end
  end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: scoreboard bench for regfile_port_ctrl with a behavioural dual-port RAM.
module tb_regfile_port_ctrl;
  localparam int DATAW = 32;
  localparam int REGW  = 5;
  localparam int NREG  = 2 ** REGW;
  localparam int FILL  = NREG / 2;
  localparam logic [DATAW-1:0] BAD = 32'hBAD0_BAD0;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, wr_en = 1'b0, init_done;
  logic [REGW-1:0] req_rs1 = '0, req_rs2 = '0, wr_addr = '0, ram_addra, ram_addrb;
  logic [DATAW-1:0] wr_data = '0, rsp_rs1_data, rsp_rs2_data, ram_dina, ram_dinb, ram_douta, ram_doutb;
  logic ram_wea, ram_web;
  logic [DATAW-1:0] mem [NREG];
  logic [DATAW-1:0] ref_mem [NREG];
  logic [2*DATAW-1:0] exp_q [$];
  logic [DATAW-1:0] last1 = '0, last2 = '0;
  bit model_run = 1'b0;
  int fill_left = FILL;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  regfile_port_ctrl #(.DATAW(DATAW), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .rsp_valid(rsp_valid),
    .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done),
    .ram_wea(ram_wea), .ram_web(ram_web), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
    .ram_dina(ram_dina), .ram_dinb(ram_dinb), .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );
  // RAM model: garbage power-up contents, and any read-during-write returns BAD.
  initial for (int i = 0; i < NREG; i++) mem[i] = 32'hA5A5_0000 | i;
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_web) mem[ram_addrb] <= ram_dinb;
    ram_douta <= (ram_wea || (ram_web && ram_addrb == ram_addra)) ? BAD : mem[ram_addra];
    ram_doutb <= (ram_web || (ram_wea && ram_addra == ram_addrb)) ? BAD : mem[ram_addrb];
  end
  task automatic do_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, init_done, ram_wea, ram_web} !== 5'b0 || ram_addra !== '0 ||
        ram_addrb !== '0 || ram_dina !== '0 || rsp_rs1_data !== '0 || rsp_rs2_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b id=%b wea=%b web=%b aa=%0d ab=%0d d1=%h d2=%h want all zero",
               req_ready, rsp_valid, init_done, ram_wea, ram_web, ram_addra, ram_addrb, rsp_rs1_data, rsp_rs2_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    last1 = '0;
    last2 = '0;
    model_run = 1'b0;
    fill_left = FILL;
    foreach (ref_mem[i]) ref_mem[i] = '0;
  endtask
  // One clock cycle: drive, check against model at negedge, update model, return just after posedge.
  task automatic step(input bit v, input logic [REGW-1:0] r1, input logic [REGW-1:0] r2,
                      input bit wen, input logic [REGW-1:0] wa, input logic [DATAW-1:0] wd);
    bit we_m, rdy_m;
    int k;
    logic [DATAW-1:0] e1, e2;
    logic [2*DATAW-1:0] pair;
    req_valid = v; req_rs1 = r1; req_rs2 = r2; wr_en = wen; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    checks++;
    if (rsp_valid !== (exp_q.size() > 0)) begin
      errors++;
      $display("FAIL rsp_valid: got %b want %b", rsp_valid, exp_q.size() > 0);
    end
    if (exp_q.size() > 0) begin
      pair = exp_q.pop_front();
      last1 = pair[2*DATAW-1:DATAW];
      last2 = pair[DATAW-1:0];
    end
    checks++;
    if (rsp_rs1_data !== last1 || rsp_rs2_data !== last2) begin
      errors++;
      $display("FAIL rsp_data: got %h/%h want %h/%h", rsp_rs1_data, rsp_rs2_data, last1, last2);
    end
    checks++;
    if (init_done !== model_run) begin
      errors++;
      $display("FAIL init_done: got %b want %b", init_done, model_run);
    end
    we_m  = model_run && wen && wa != '0;
    rdy_m = model_run && !(we_m && r1 != '0 && r1 != wa && r1 != r2);
    checks++;
    if (req_ready !== rdy_m) begin
      errors++;
      $display("FAIL req_ready: got %b want %b (rs1=%0d rs2=%0d wa=%0d we=%b)", req_ready, rdy_m, r1, r2, wa, we_m);
    end
    checks++;
    if (!model_run) begin
      k = FILL - fill_left;
      if ({ram_wea, ram_web, ram_addra, ram_addrb, ram_dina, ram_dinb} !==
          {2'b11, REGW'(2 * k), REGW'(2 * k + 1), {2*DATAW{1'b0}}}) begin
        errors++;
        $display("FAIL init_ports: got wea=%b web=%b aa=%0d ab=%0d da=%h db=%h want 1 1 %0d %0d 0 0",
                 ram_wea, ram_web, ram_addra, ram_addrb, ram_dina, ram_dinb, 2 * k, 2 * k + 1);
      end
    end else if (ram_wea !== we_m || ram_web !== 1'b0 || (we_m && (ram_addra !== wa || ram_dina !== wd)) ||
                 (!we_m && v && ram_addra !== r1) || (v && ram_addrb !== r2)) begin
      errors++;
      $display("FAIL run_ports: got wea=%b web=%b aa=%0d ab=%0d da=%h want wea=%b web=0 (wa=%0d rs1=%0d rs2=%0d wd=%h)",
               ram_wea, ram_web, ram_addra, ram_addrb, ram_dina, we_m, wa, r1, r2, wd);
    end
    if (v && rdy_m) begin
      e1 = r1 == '0 ? '0 : (we_m && r1 == wa) ? wd : ref_mem[r1];
      e2 = r2 == '0 ? '0 : (we_m && r2 == wa) ? wd : ref_mem[r2];
      exp_q.push_back({e1, e2});
    end
    if (we_m) ref_mem[wa] = wd;
    if (!model_run) begin
      fill_left--;
      if (fill_left == 0) model_run = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask
  task automatic fill();
    repeat (FILL) step(1'b1, 5'd5, 5'd6, 1'b1, 5'd3, $urandom);
  endtask
  task automatic test_reset();
    do_reset();
    fill();
    step(1'b1, 5'd5, 5'd6, 1'b0, '0, '0);
    step(1'b1, 5'd3, 5'd0, 1'b0, '0, '0);
    idle();
  endtask
  task automatic test_write_read();
    step(1'b0, '0, '0, 1'b1, 5'd3, 32'hDEADBEEF);
    step(1'b1, 5'd3, 5'd0, 1'b0, '0, '0);
    idle();
  endtask
  task automatic test_forward();
    step(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678);
    step(1'b1, 5'd8, 5'd8, 1'b1, 5'd8, 32'h0BADF00D);
    step(1'b1, 5'd1, 5'd8, 1'b1, 5'd8, 32'h00C0FFEE);
    idle();
  endtask
  task automatic test_stall();
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99999999);
    step(1'b0, '0, '0, 1'b1, 5'd10, 32'hAAAA1010);
    step(1'b1, 5'd9, 5'd10, 1'b1, 5'd4, 32'h0000000A);
    step(1'b1, 5'd9, 5'd10, 1'b0, '0, '0);
    idle();
    step(1'b1, 5'd4, 5'd9, 1'b1, 5'd4, 32'h44);
    idle();
  endtask
  task automatic test_x0();
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 5'd0, 5'd3, 1'b0, '0, '0);
    idle();
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, REGW'($urandom_range(0, 7)), REGW'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, REGW'($urandom_range(0, 7)), $urandom);
    for (int i = 0; i < 20; i++) step(1'b1, REGW'(i), REGW'(i + 1), 1'b0, '0, '0);
    idle();
  endtask
  task automatic test_reset_restart();
    do_reset();
    repeat (5) step(1'b0, '0, '0, 1'b0, '0, '0);
    do_reset();
    fill();
    step(1'b0, '0, '0, 1'b1, 5'd2, 32'h1);
    step(1'b1, 5'd2, 5'd2, 1'b0, '0, '0);
    idle();
    step(1'b1, 5'd2, 5'd3, 1'b0, '0, '0);
    do_reset();
    fill();
    step(1'b1, 5'd2, 5'd31, 1'b0, '0, '0);
    idle();
  endtask
  initial begin
    #2;
    test_reset();
    test_write_read();
    test_forward();
    test_stall();
    test_x0();
    test_back_to_back();
    test_reset_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
